rf_write_arbiter: RTL and testbench

Shares the single write port of the 32x32 register file between several writeback sources (ALU, load unit, multiply/divide unit). Each source presents a valid/ready request. A round-robin arbiter grants one request per cycle and drives the register-file write port through one registered stage. Writes to register 0 are acknowledged but never issued. Sits between the writeback stage and the register file. Also exports the in-flight write for hazard/bypass logic.

---
 rtl/rf_write_arbiter.sv | 97 +++++++++
 tb/tb_rf_write_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin writeback arbiter driving the register-file write port
module rf_write_arbiter #(
    parameter int N = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [5*N-1:0]  req_reg,
    input  logic [32*N-1:0] req_data,
    output logic [N-1:0]    req_ready,
    input  logic            hold,
    output logic            rf_write,
    output logic [4:0]      rf_write_reg,
    output logic [31:0]     rf_write_data,
    output logic [2:0]      rf_grant_id
);

    logic [2:0]  r_ptr;
    logic        r_write;
    logic [4:0]  r_reg;
    logic [31:0] r_data;
    logic [2:0]  r_id;

    logic [7:0]  w_valid8;
    logic [4:0]  w_regs  [8];
    logic [31:0] w_datas [8];
    logic [2:0]  w_gnt;
    logic [2:0]  w_ptr_nxt;
    logic        w_xfer;

    // Pad requester vectors to 8 entries so a 3-bit index is always in range.
    always_comb begin
        w_valid8 = '0;
        w_valid8[N-1:0] = req_valid;
        for (int i = 0; i < 8; i++) begin
            w_regs[i]  = '0;
            w_datas[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            w_regs[i]  = req_reg[5*i +: 5];
            w_datas[i] = req_data[32*i +: 32];
        end
    end

    always_comb begin : arb
        logic [3:0] v_idx;
        v_idx  = '0;
        w_gnt  = '0;
        w_xfer = 1'b0;
        for (int k = 0; k < N; k++) begin
            v_idx = {1'b0, r_ptr} + 4'(k);
            if (v_idx >= 4'(N))
                v_idx = v_idx - 4'(N);
            if (!w_xfer && w_valid8[v_idx[2:0]]) begin
                w_xfer = 1'b1;
                w_gnt  = v_idx[2:0];
            end
        end
        if (!rst || hold) begin
            w_xfer = 1'b0;
            w_gnt  = '0;
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N; i++)
            req_ready[i] = w_xfer && (w_gnt == 3'(i));
    end

    assign w_ptr_nxt = (w_gnt == 3'(N-1)) ? 3'd0 : w_gnt + 3'd1;

    // Register-0 writes are acknowledged and advance the pointer but never strobe the port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_write <= 1'b0;
            r_reg   <= '0;
            r_data  <= '0;
            r_id    <= '0;
        end else if (w_xfer) begin
            r_ptr   <= w_ptr_nxt;
            r_write <= (w_regs[w_gnt] != 5'd0);
            r_reg   <= w_regs[w_gnt];
            r_data  <= w_datas[w_gnt];
            r_id    <= w_gnt;
        end else begin
            r_write <= 1'b0;
        end
    end

    assign rf_write      = r_write;
    assign rf_write_reg  = r_reg;
    assign rf_write_data = r_data;
    assign rf_grant_id   = r_id;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - table-driven and scoreboard bench for rf_write_arbiter
module tb_rf_write_arbiter;

    localparam int N = 3;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [5*N-1:0]  req_reg;
    logic [32*N-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            hold;
    logic            rf_write;
    logic [4:0]      rf_write_reg;
    logic [31:0]     rf_write_data;
    logic [2:0]      rf_grant_id;

    rf_write_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
        .req_ready(req_ready), .hold(hold),
        .rf_write(rf_write), .rf_write_reg(rf_write_reg),
        .rf_write_data(rf_write_data), .rf_grant_id(rf_grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic        hold;
        logic [14:0] regs;
        logic [95:0] data;
        logic [2:0]  exp_ready;
        string       name;
    } vec_t;

    typedef struct {
        logic        w;
        logic [4:0]  r;
        logic [31:0] d;
        logic [2:0]  id;
    } out_t;

    vec_t tbl[$];
    out_t sb[$];
    out_t m_last;
    int   errors = 0;
    int   checks = 0;

    localparam logic [14:0] R_DEF  = {5'd17, 5'd9, 5'd5};
    localparam logic [95:0] D_DEF  = {32'h2222_0002, 32'h1111_0001, 32'hDEAD_BEEF};
    localparam logic [14:0] R_ZERO = {5'd17, 5'd0, 5'd5};
    localparam logic [95:0] D_ZERO = {32'h2222_0002, 32'h0000_1234, 32'hDEAD_BEEF};
    localparam logic [14:0] R_SAME = {5'd17, 5'd7, 5'd7};
    localparam logic [95:0] D_SAME = {32'h2222_0002, 32'hBBBB_0007, 32'hAAAA_0007};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input out_t e);
        chk({nm, "_rf_write"}, 32'(rf_write), 32'(e.w));
        chk({nm, "_rf_reg"}, 32'(rf_write_reg), 32'(e.r));
        chk({nm, "_rf_data"}, rf_write_data, e.d);
        chk({nm, "_rf_id"}, 32'(rf_grant_id), 32'(e.id));
    endtask

    function automatic void add(input logic [2:0] v, input logic h, input logic [14:0] rg,
                                input logic [95:0] dt, input logic [2:0] er, input string nm);
        vec_t t;
        t.valid = v; t.hold = h; t.regs = rg; t.data = dt; t.exp_ready = er; t.name = nm;
        tbl.push_back(t);
    endfunction

    // Drive one cycle, check the previous cycle's write and this cycle's acknowledge.
    task automatic step(input logic [2:0] v, input logic h, input logic [14:0] rg,
                        input logic [95:0] dt, input logic [2:0] er, input string nm);
        out_t e;
        out_t o;
        req_valid = v; hold = h; req_reg = rg; req_data = dt;
        @(negedge clk);
        if (sb.size() > 0) begin
            o = sb.pop_front();
            chk_out(nm, o);
        end
        chk({nm, "_ready"}, 32'(req_ready), 32'(er));
        e   = m_last;
        e.w = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (er[i]) begin
                e.r  = rg[5*i +: 5];
                e.d  = dt[32*i +: 32];
                e.id = 3'(i);
                e.w  = (e.r != 5'd0);
            end
        end
        sb.push_back(e);
        m_last = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        out_t z;
        out_t o;
        z = '{w: 1'b0, r: 5'd0, d: 32'd0, id: 3'd0};
        rst = 1'b0; hold = 1'b0;
        req_valid = 3'b111; req_reg = R_DEF; req_data = D_DEF;
        #3;
        chk_out("reset", z);
        chk("reset_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_last = z;

        add(3'b111, 1'b0, R_DEF, D_DEF, 3'b001, "fair0");
        add(3'b111, 1'b0, R_DEF, D_DEF, 3'b010, "fair1");
        add(3'b111, 1'b0, R_DEF, D_DEF, 3'b100, "fair2");
        add(3'b111, 1'b0, R_DEF, D_DEF, 3'b001, "fair3");
        add(3'b111, 1'b0, R_DEF, D_DEF, 3'b010, "fair4");
        add(3'b111, 1'b0, R_DEF, D_DEF, 3'b100, "fair5");
        add(3'b001, 1'b0, R_DEF, D_DEF, 3'b001, "single");
        add(3'b000, 1'b0, R_DEF, D_DEF, 3'b000, "idle");
        add(3'b100, 1'b0, R_DEF, D_DEF, 3'b100, "only2");
        add(3'b111, 1'b0, R_DEF, D_DEF, 3'b001, "after2_a");
        add(3'b111, 1'b0, R_DEF, D_DEF, 3'b010, "after2_b");
        add(3'b111, 1'b0, R_DEF, D_DEF, 3'b100, "after2_c");
        add(3'b010, 1'b0, R_ZERO, D_ZERO, 3'b010, "reg0");
        add(3'b111, 1'b0, R_DEF, D_DEF, 3'b100, "reg0_ptr");
        add(3'b111, 1'b1, R_DEF, D_DEF, 3'b000, "hold0");
        add(3'b111, 1'b1, R_DEF, D_DEF, 3'b000, "hold1");
        add(3'b111, 1'b1, R_DEF, D_DEF, 3'b000, "hold2");
        add(3'b111, 1'b0, R_DEF, D_DEF, 3'b001, "unhold_a");
        add(3'b111, 1'b0, R_DEF, D_DEF, 3'b010, "unhold_b");
        add(3'b011, 1'b0, R_DEF, D_DEF, 3'b001, "wrap");
        add(3'b011, 1'b0, R_SAME, D_SAME, 3'b010, "same_a");
        add(3'b011, 1'b0, R_SAME, D_SAME, 3'b001, "same_b");
        add(3'b000, 1'b0, R_DEF, D_DEF, 3'b000, "drain");

        foreach (tbl[i])
            step(tbl[i].valid, tbl[i].hold, tbl[i].regs, tbl[i].data, tbl[i].exp_ready, tbl[i].name);

        // Reset landing on a write in the output stage.
        step(3'b001, 1'b0, R_DEF, {D_DEF[95:32], 32'hAAAA_5555}, 3'b001, "mid_xfer");
        o = sb.pop_front();
        chk_out("mid_out", o);
        #2;
        rst = 1'b0;
        #1;
        chk_out("mid_rst", z);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 3'b000;
        @(posedge clk);
        #1;
        m_last = z;
        step(3'b000, 1'b0, R_DEF, D_DEF, 3'b000, "post_idle0");
        step(3'b000, 1'b0, R_DEF, D_DEF, 3'b000, "post_idle1");
        step(3'b010, 1'b0, R_DEF, D_DEF, 3'b010, "post_xfer");
        step(3'b000, 1'b0, R_DEF, D_DEF, 3'b000, "post_drain");
        step(3'b000, 1'b0, R_DEF, D_DEF, 3'b000, "post_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
